// File: rtl/bist_signature_analyzer.sv
// Response compactor for the BIST controller: folds RESP into a MISR while a run
// is in progress, then compares signature and capture count against golden values.
module bist_signature_analyzer #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] POLY         = 8'hB8,
  parameter logic [WIDTH-1:0] SEED         = 8'hFF,
  parameter logic [WIDTH-1:0] GOLDEN       = 8'h00,
  parameter int               EXP_CAPTURES = 87
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             RUNNING,
  input  logic             CAP_EN,
  input  logic             BIST_END,
  input  logic [WIDTH-1:0] RESP,
  input  logic             CLR,
  output logic [WIDTH-1:0] SIGNATURE,
  output logic [7:0]       CAPTURES,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic             FAIL
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPACT = 2'd1,
    S_COMPARE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sig_nxt;
  logic [7:0]       cap_nxt;
  logic             pass_nxt, fail_nxt;
  logic             capture;
  logic             fb;
  logic             match;

  assign fb    = ^(SIGNATURE & POLY);
  assign match = (SIGNATURE == GOLDEN) && (CAPTURES == 8'(EXP_CAPTURES));

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_nxt = state;
    sig_nxt   = SIGNATURE;
    cap_nxt   = CAPTURES;
    pass_nxt  = PASS;
    fail_nxt  = FAIL;
    capture   = RUNNING && CAP_EN && (state == S_IDLE || state == S_COMPACT);

    if (capture) begin
      sig_nxt = {SIGNATURE[WIDTH-2:0], fb} ^ RESP;
      if (CAPTURES != 8'hFF) cap_nxt = CAPTURES + 8'd1;
    end

    if (CLR) begin
      state_nxt = S_IDLE;
      sig_nxt   = SEED;
      cap_nxt   = 8'd0;
      pass_nxt  = 1'b0;
      fail_nxt  = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (RUNNING) state_nxt = S_COMPACT;
        end
        S_COMPACT: begin
          // RUNNING dominates BIST_END; a drop without BIST_END is an aborted run.
          if (!RUNNING) begin
            if (BIST_END) begin
              state_nxt = S_COMPARE;
            end else begin
              state_nxt = S_DONE;
              pass_nxt  = 1'b0;
              fail_nxt  = 1'b1;
            end
          end
        end
        S_COMPARE: begin
          state_nxt = S_DONE;
          pass_nxt  = match;
          fail_nxt  = !match;
        end
        S_DONE: begin
          state_nxt = S_DONE;
        end
        default: begin
          state_nxt = S_IDLE;
          sig_nxt   = SEED;
          cap_nxt   = 8'd0;
          pass_nxt  = 1'b0;
          fail_nxt  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= S_IDLE;
      SIGNATURE <= SEED;
      CAPTURES  <= 8'd0;
      PASS      <= 1'b0;
      FAIL      <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register is updated from pre-edge values.
      state     <= state_nxt;
      SIGNATURE <= sig_nxt;
      CAPTURES  <= cap_nxt;
      PASS      <= pass_nxt;
      FAIL      <= fail_nxt;
    end
  end

  assign BUSY = (state == S_COMPACT) || (state == S_COMPARE);
  assign DONE = (state == S_DONE);

endmodule

// File: doc/bist_signature_analyzer.md
Name: bist_signature_analyzer

Overview:
- Response-compaction stage directly downstream of the BIST sequencing controller.
- While the controller reports a run in progress, the block compacts the circuit-under-test response bus into a multiple-input signature register (MISR) on every capture-enabled cycle.
- At end of test it compares the signature and the capture count against golden values and raises sticky PASS/FAIL plus DONE for the top level.

Parameters:
- WIDTH, 8, width of response bus and MISR.
- POLY, 8'hB8, MISR feedback tap mask (bit i set = sig[i] feeds back).
- SEED, 8'hFF, MISR initial value.
- GOLDEN, 8'h00, expected final signature (set per CUT by integration).
- EXP_CAPTURES, 87, expected number of compacted cycles per run.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- RUNNING  in  1  run-in-progress flag from the BIST controller.
- CAP_EN  in  1  capture enable from the BIST controller; high = compact RESP this cycle.
- BIST_END  in  1  end-of-test flag from the BIST controller.
- RESP  in  WIDTH  CUT response vector, sampled on CLK.
- CLR  in  1  synchronous clear of a finished result; returns to IDLE.
- SIGNATURE  out  WIDTH  current MISR contents (registered).
- CAPTURES  out  8  number of compacted cycles, saturating at 255.
- BUSY  out  1  high in COMPACT and COMPARE.
- DONE  out  1  high in DONE state.
- PASS  out  1  sticky pass result, valid when DONE=1.
- FAIL  out  1  sticky fail result, valid when DONE=1.

Behaviour:
- Reset (async, RESET=1): state=IDLE, SIGNATURE=SEED, CAPTURES=0, BUSY=DONE=PASS=FAIL=0.
- MISR update:
  - fb = XOR-reduce(SIGNATURE & POLY).
  - next = {SIGNATURE[WIDTH-2:0], fb} ^ RESP.
  - Applied on a rising edge when state is IDLE or COMPACT, RUNNING=1 and CAP_EN=1.
  - CAPTURES increments on the same edge, saturating at 255.
  - CAP_EN is ignored while RUNNING=0.
- Latency: SIGNATURE reflects a capture one cycle after the sampling edge.
- FSM states IDLE, COMPACT, COMPARE, DONE, all registered:
  - IDLE: SIGNATURE and CAPTURES hold SEED and 0. RUNNING=1 -> COMPACT; the first cycle's capture is taken in IDLE, so no capture is lost.
  - COMPACT: RUNNING=1 -> stay; RUNNING=1 together with BIST_END=1 also stays (RUNNING dominates). RUNNING=0 with BIST_END=1 -> COMPARE. RUNNING=0 with BIST_END=0 is an aborted run -> DONE with FAIL=1, PASS=0.
  - COMPARE: single cycle. PASS = (SIGNATURE==GOLDEN) && (CAPTURES==EXP_CAPTURES); FAIL = !PASS. Both registered on exit -> DONE.
  - DONE: DONE=1; PASS, FAIL, SIGNATURE and CAPTURES frozen; RUNNING and CAP_EN ignored. CLR=1 -> IDLE, reloading SIGNATURE=SEED and CAPTURES=0 on the same edge.
- CLR in IDLE or COMPACT: abort to IDLE with reload; no result is produced. CLR has priority over all other transitions.
- PASS and FAIL are never both 1 and are both 0 outside DONE.
- RESET mid-run: immediate asynchronous return to the reset values above.
- Unused state encodings -> IDLE on the next edge with reload.

Test Plan:
- Reset then idle with RUNNING=0 for 10 cycles -> SIGNATURE=8'hFF, CAPTURES=0, BUSY=DONE=PASS=FAIL=0.
- One run with RESP=0: first capture -> SIGNATURE=8'hFE, second capture -> SIGNATURE=8'hFC; CAPTURES tracks the number of CAP_EN-high cycles.
- Full run of 90 RUNNING cycles with CAP_EN low on 3 of them, then BIST_END=1; GOLDEN set to the model signature -> CAPTURES=87, PASS=1, FAIL=0, DONE=1 two cycles after RUNNING falls.
- Same run with one flipped RESP bit in mid-run -> SIGNATURE differs from GOLDEN, FAIL=1, PASS=0.
- RUNNING drops after 40 cycles with BIST_END=0 -> DONE=1, FAIL=1. Then CLR=1 -> IDLE, SIGNATURE=8'hFF, DONE=0.
- RESET asserted asynchronously mid-COMPACT, and CLR asserted mid-COMPACT -> both return to IDLE with SEED; a following clean run yields PASS=1.
